// File: rtl/cmos_capture_rgb565.sv
`default_nettype none
// ============================================================================
// Module   : cmos_capture_rgb565
// Brief    : OV7670 byte-bus capture, RGB565 packing, frame skip, geometry check
// Revision : 1.0
// ============================================================================
module cmos_capture_rgb565 #(
    parameter int FRAME_SKIP = 10,
    parameter int H_PIXELS   = 640,
    parameter int V_LINES    = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_done,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    output logic        cmos_frame_clken,
    output logic [15:0] cmos_frame_data,
    output logic        cmos_frame_valid,
    output logic [7:0]  frame_cnt,
    output logic        geom_err
);

    localparam logic [1:0]  S_WAIT_INIT = 2'd0;
    localparam logic [1:0]  S_SKIP      = 2'd1;
    localparam logic [1:0]  S_CAPTURE   = 2'd2;
    localparam logic [3:0]  c_skip_last = 4'(FRAME_SKIP - 1);
    localparam logic [10:0] c_h_pixels  = 11'(H_PIXELS);
    localparam logic [9:0]  c_v_lines   = 10'(V_LINES);

    logic        r_init_s1, r_init_s2;
    logic        r_vs1, r_vs2, r_href1, r_href2;
    logic [7:0]  r_data1;
    logic [1:0]  r_state, w_state_nxt;
    logic [3:0]  r_skip_cnt;
    logic        r_toggle;
    logic [7:0]  r_hi_byte;
    logic        r_pair_valid;
    logic [15:0] r_pair_data;
    logic [10:0] r_pix_cnt;
    logic [9:0]  r_line_cnt, w_line_eff;
    logic        r_chk_arm;
    logic        w_vs_rise, w_href_fall, w_init_ok, w_pair_done;
    logic        w_capture, w_valid_nxt;

    assign w_vs_rise   = r_vs1 & ~r_vs2;
    assign w_href_fall = ~r_href1 & r_href2;
    assign w_init_ok   = r_init_s2;
    assign w_pair_done = r_href1 & r_toggle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_s1 <= 1'b0;
            r_init_s2 <= 1'b0;
            r_vs1     <= 1'b0;
            r_vs2     <= 1'b0;
            r_href1   <= 1'b0;
            r_href2   <= 1'b0;
            r_data1   <= 8'h00;
        end else begin
            r_init_s1 <= init_done;
            r_init_s2 <= r_init_s1;
            r_vs1     <= cmos_vsync;
            r_vs2     <= r_vs1;
            r_href1   <= cmos_href;
            r_href2   <= r_href1;
            r_data1   <= cmos_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_INIT: if (w_init_ok && w_vs_rise) w_state_nxt = S_SKIP;
            S_SKIP: begin
                if (!w_init_ok)
                    w_state_nxt = S_WAIT_INIT;
                else if (w_vs_rise && (r_skip_cnt == c_skip_last))
                    w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE:   if (!w_init_ok) w_state_nxt = S_WAIT_INIT;
            default:     w_state_nxt = S_WAIT_INIT;
        endcase
    end

    // Losing init_done while capturing counts as leaving capture this cycle.
    always_comb begin
        w_capture   = (r_state == S_CAPTURE) && w_init_ok;
        w_valid_nxt = (w_state_nxt == S_CAPTURE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skip_cnt <= 4'd0;
        end else if (r_state != S_SKIP) begin
            r_skip_cnt <= 4'd0;
        end else if (w_vs_rise) begin
            r_skip_cnt <= r_skip_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_toggle     <= 1'b0;
            r_hi_byte    <= 8'h00;
            r_pair_valid <= 1'b0;
            r_pair_data  <= 16'h0000;
        end else begin
            if (!r_href1 || !w_init_ok)
                r_toggle <= 1'b0;
            else
                r_toggle <= ~r_toggle;
            if (r_href1 && !r_toggle)
                r_hi_byte <= r_data1;
            r_pair_valid <= w_pair_done && w_capture;
            if (w_pair_done)
                r_pair_data <= {r_hi_byte, r_data1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmos_frame_clken <= 1'b0;
            cmos_frame_data  <= 16'h0000;
            cmos_frame_valid <= 1'b0;
        end else begin
            cmos_frame_clken <= r_pair_valid && w_valid_nxt;
            if (r_pair_valid && w_valid_nxt)
                cmos_frame_data <= r_pair_data;
            cmos_frame_valid <= w_valid_nxt;
        end
    end

    // Line count including a line ending on this very cycle.
    always_comb begin
        w_line_eff = r_line_cnt;
        if (w_href_fall && (r_line_cnt != '1))
            w_line_eff = r_line_cnt + 10'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt  <= 11'd0;
            r_line_cnt <= 10'd0;
            r_chk_arm  <= 1'b0;
            geom_err   <= 1'b0;
            frame_cnt  <= 8'd0;
        end else if (!w_capture) begin
            r_pix_cnt  <= 11'd0;
            r_line_cnt <= 10'd0;
            r_chk_arm  <= 1'b0;
        end else begin
            if (w_href_fall)
                r_pix_cnt <= 11'd0;
            else if (w_pair_done && (r_pix_cnt != '1))
                r_pix_cnt <= r_pix_cnt + 11'd1;
            if (w_href_fall && ((r_pix_cnt != c_h_pixels) || r_toggle))
                geom_err <= 1'b1;
            if (w_vs_rise) begin
                if (r_chk_arm && (w_line_eff != c_v_lines))
                    geom_err <= 1'b1;
                r_line_cnt <= 10'd0;
                r_chk_arm  <= 1'b1;
                frame_cnt  <= frame_cnt + 8'd1;
            end else begin
                r_line_cnt <= w_line_eff;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmos_capture_rgb565.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmos_capture_rgb565
// Brief    : Directed self-checking bench for cmos_capture_rgb565 (4x3 frames)
// Revision : 1.0
// ============================================================================
module tb_cmos_capture_rgb565;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done = 1'b0;
    logic        cmos_vsync = 1'b0;
    logic        cmos_href = 1'b0;
    logic [7:0]  cmos_data = 8'h00;
    logic        cmos_frame_clken;
    logic [15:0] cmos_frame_data;
    logic        cmos_frame_valid;
    logic [7:0]  frame_cnt;
    logic        geom_err;

    int n_cmp = 0;
    int n_bad = 0;
    int strobes = 0;

    cmos_capture_rgb565 #(
        .FRAME_SKIP (2),
        .H_PIXELS   (4),
        .V_LINES    (3)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .init_done        (init_done),
        .cmos_vsync       (cmos_vsync),
        .cmos_href        (cmos_href),
        .cmos_data        (cmos_data),
        .cmos_frame_clken (cmos_frame_clken),
        .cmos_frame_data  (cmos_frame_data),
        .cmos_frame_valid (cmos_frame_valid),
        .frame_cnt        (frame_cnt),
        .geom_err         (geom_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmos_frame_clken === 1'b1)
            strobes <= strobes + 1;
    end

    task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
        @(negedge clk);
        cmos_vsync = vs;
        cmos_href  = hr;
        cmos_data  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_vsync();
        idle(2);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        idle(2);
    endtask

    task automatic send_line(input int nbytes, input int base);
        for (int i = 0; i < nbytes; i++) drive(1'b0, 1'b1, 8'(base + i));
        idle(4);
    endtask

    task automatic send_frame(input int odd_line);
        send_vsync();
        for (int l = 0; l < 3; l++) send_line((l == odd_line) ? 9 : 8, 16 * l + 1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (cmos_frame_clken !== 1'b0) begin n_bad++; $display("FAIL reset_clken: got %b want 0", cmos_frame_clken); end
        n_cmp++; if (cmos_frame_data !== 16'h0000) begin n_bad++; $display("FAIL reset_data: got %h want 0000", cmos_frame_data); end
        n_cmp++; if (cmos_frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", cmos_frame_valid); end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        n_cmp++; if (geom_err !== 1'b0) begin n_bad++; $display("FAIL reset_geom_err: got %b want 0", geom_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_no_init();
        int c0;
        c0 = strobes;
        repeat (3) send_frame(-1);
        n_cmp++; if (strobes - c0 !== 0) begin n_bad++; $display("FAIL noinit_strobes: got %0d want 0", strobes - c0); end
        n_cmp++; if (cmos_frame_valid !== 1'b0) begin n_bad++; $display("FAIL noinit_valid: got %b want 0", cmos_frame_valid); end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL noinit_frame_cnt: got %0d want 0", frame_cnt); end
    endtask

    task automatic test_skip_capture();
        int c0;
        init_done = 1'b1;
        idle(4);
        c0 = strobes;
        send_frame(-1);
        send_frame(-1);
        n_cmp++; if (cmos_frame_valid !== 1'b0) begin n_bad++; $display("FAIL skip_valid: got %b want 0", cmos_frame_valid); end
        n_cmp++; if (strobes - c0 !== 0) begin n_bad++; $display("FAIL skip_strobes: got %0d want 0", strobes - c0); end
        c0 = strobes;
        send_frame(-1);
        n_cmp++; if (cmos_frame_valid !== 1'b1) begin n_bad++; $display("FAIL capture_valid: got %b want 1", cmos_frame_valid); end
        n_cmp++; if (strobes - c0 !== 12) begin n_bad++; $display("FAIL first_frame_strobes: got %0d want 12", strobes - c0); end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL first_frame_cnt: got %0d want 0", frame_cnt); end
        c0 = strobes;
        send_frame(-1);
        n_cmp++; if (frame_cnt !== 8'd1) begin n_bad++; $display("FAIL second_frame_cnt: got %0d want 1", frame_cnt); end
        n_cmp++; if (strobes - c0 !== 12) begin n_bad++; $display("FAIL second_frame_strobes: got %0d want 12", strobes - c0); end
        n_cmp++; if (geom_err !== 1'b0) begin n_bad++; $display("FAIL clean_geom_err: got %b want 0", geom_err); end
    endtask

    task automatic test_pixel_latency();
        logic [7:0] b [8];
        b = '{8'hF8, 8'h1F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_vsync();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, b[i]);
            @(posedge clk); #1;
            if (i == 1 || i == 2 || i == 4) begin
                n_cmp++; if (cmos_frame_clken !== 1'b0) begin n_bad++; $display("FAIL latency_early_clken@%0d: got %b want 0", i, cmos_frame_clken); end
            end
            if (i == 3) begin
                n_cmp++; if (cmos_frame_clken !== 1'b1) begin n_bad++; $display("FAIL latency_clken: got %b want 1", cmos_frame_clken); end
                n_cmp++; if (cmos_frame_data !== 16'hF81F) begin n_bad++; $display("FAIL latency_data: got %h want f81f", cmos_frame_data); end
            end
            if (i == 4) begin
                n_cmp++; if (cmos_frame_data !== 16'hF81F) begin n_bad++; $display("FAIL data_hold: got %h want f81f", cmos_frame_data); end
            end
        end
        idle(4);
        n_cmp++; if (cmos_frame_data !== 16'h0506) begin n_bad++; $display("FAIL last_pair_data: got %h want 0506", cmos_frame_data); end
        send_line(8, 16);
        send_line(8, 32);
        n_cmp++; if (frame_cnt !== 8'd2) begin n_bad++; $display("FAIL latency_frame_cnt: got %0d want 2", frame_cnt); end
        n_cmp++; if (geom_err !== 1'b0) begin n_bad++; $display("FAIL latency_geom_err: got %b want 0", geom_err); end
    endtask

    task automatic test_odd_line();
        int c0;
        send_vsync();
        c0 = strobes;
        send_line(9, 8'h40);
        n_cmp++; if (strobes - c0 !== 4) begin n_bad++; $display("FAIL odd_line_strobes: got %0d want 4", strobes - c0); end
        n_cmp++; if (geom_err !== 1'b1) begin n_bad++; $display("FAIL odd_line_geom_err: got %b want 1", geom_err); end
        send_line(8, 16);
        send_line(8, 32);
        c0 = strobes;
        send_frame(-1);
        n_cmp++; if (geom_err !== 1'b1) begin n_bad++; $display("FAIL geom_err_sticky: got %b want 1", geom_err); end
        n_cmp++; if (strobes - c0 !== 12) begin n_bad++; $display("FAIL after_odd_strobes: got %0d want 12", strobes - c0); end
    endtask

    task automatic test_init_loss();
        int c0;
        send_vsync();
        c0 = strobes;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 8'(8'h60 + i));
            if (i == 2) init_done = 1'b0;
            if (i >= 2) begin
                @(posedge clk); #1;
                if (i == 3) begin
                    n_cmp++; if (cmos_frame_valid !== 1'b1) begin n_bad++; $display("FAIL loss_valid_sync: got %b want 1", cmos_frame_valid); end
                end
                if (i == 4) begin
                    n_cmp++; if (cmos_frame_valid !== 1'b0) begin n_bad++; $display("FAIL loss_valid_drop: got %b want 0", cmos_frame_valid); end
                    n_cmp++; if (cmos_frame_clken !== 1'b0) begin n_bad++; $display("FAIL loss_clken: got %b want 0", cmos_frame_clken); end
                end
            end
        end
        idle(4);
        send_line(8, 16);
        send_line(8, 32);
        n_cmp++; if (strobes - c0 !== 1) begin n_bad++; $display("FAIL loss_strobes: got %0d want 1", strobes - c0); end
        init_done = 1'b1;
        idle(4);
        c0 = strobes;
        send_frame(-1);
        send_frame(-1);
        n_cmp++; if (cmos_frame_valid !== 1'b0) begin n_bad++; $display("FAIL reskip_valid: got %b want 0", cmos_frame_valid); end
        n_cmp++; if (strobes - c0 !== 0) begin n_bad++; $display("FAIL reskip_strobes: got %0d want 0", strobes - c0); end
        c0 = strobes;
        send_frame(-1);
        n_cmp++; if (cmos_frame_valid !== 1'b1) begin n_bad++; $display("FAIL resume_valid: got %b want 1", cmos_frame_valid); end
        n_cmp++; if (strobes - c0 !== 12) begin n_bad++; $display("FAIL resume_strobes: got %0d want 12", strobes - c0); end
        n_cmp++; if (frame_cnt !== 8'd5) begin n_bad++; $display("FAIL resume_frame_cnt: got %0d want 5", frame_cnt); end
    endtask

    task automatic test_reset_mid_pair();
        int c0;
        drive(1'b0, 1'b1, 8'hAA);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (cmos_frame_clken !== 1'b0) begin n_bad++; $display("FAIL midrst_clken: got %b want 0", cmos_frame_clken); end
        n_cmp++; if (cmos_frame_data !== 16'h0000) begin n_bad++; $display("FAIL midrst_data: got %h want 0000", cmos_frame_data); end
        n_cmp++; if (cmos_frame_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", cmos_frame_valid); end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL midrst_frame_cnt: got %0d want 0", frame_cnt); end
        n_cmp++; if (geom_err !== 1'b0) begin n_bad++; $display("FAIL midrst_geom_err: got %b want 0", geom_err); end
        @(negedge clk);
        cmos_href = 1'b0;
        rst_n = 1'b1;
        c0 = strobes;
        send_frame(-1);
        n_cmp++; if (cmos_frame_valid !== 1'b0) begin n_bad++; $display("FAIL postrst_valid: got %b want 0", cmos_frame_valid); end
        n_cmp++; if (strobes - c0 !== 0) begin n_bad++; $display("FAIL postrst_strobes: got %0d want 0", strobes - c0); end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL postrst_frame_cnt: got %0d want 0", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_no_init();
        test_skip_capture();
        test_pixel_latency();
        test_odd_line();
        test_init_loss();
        test_reset_mid_pair();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
